// File: rtl/disp_scan.sv
// disp_scan: four-digit multiplexed display scanner feeding a 7-segment decoder.
//
// The 16-bit input value is copied into a shadow register once per frame, so a
// frame never mixes old and new digits. Each digit slot lasts DIV cycles. The
// first GUARD cycles of every slot are blanked to suppress ghosting.
//
// Optional feature: define DISP_LZB_EN to enable leading-zero blanking. Digits
// 1..3 are then suppressed when their nibble and all higher nibbles are zero.
//
// Parameters:
//   DIV    clock cycles per digit slot (>= 2)
//   GUARD  blanked cycles at the start of each slot (0 <= GUARD < DIV)
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   val    value to display; nibble i goes to digit i (digit 0 = LSD)
//   blank  per-digit force-dark mask, sampled live
//   bcd    nibble for the decoder input
//   en     decoder enable (0 = all segments off)
//   an     active-low anode selects, at most one bit low
//   frm    one-cycle pulse in cycle 0 of every frame
module disp_scan #(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic [3:0]  blank,
  output logic [3:0]  bcd,
  output logic        en,
  output logic [3:0]  an,
  output logic        frm
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   sh_reg, sh_next;
  // Low in reset: the first edge after release enters cycle 0 of digit 0
  // instead of advancing the counter.
  logic          run_reg;

  logic [3:0]    bcd_reg, bcd_next;
  logic          en_reg, en_next;
  logic [3:0]    an_reg, an_next;
  logic          frm_reg, frm_next;

  logic [3:0]    nib [4];
  logic          guard_ok;
  logic          lzb_ok;
  logic          lit;

  // Outputs are computed from the next state and registered, so every output
  // describes the same cycle as the state it came from.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = sh_next[4*gi +: 4];
    end

    if (GUARD == 0) begin : g_noguard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (cnt_next >= CW'(GUARD));
    end
  endgenerate

`ifdef DISP_LZB_EN
  // hi_nz[i]: nibble i or any more significant nibble is non-zero.
  logic [3:0] hi_nz;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lzb
      assign hi_nz[gi] = |sh_next[15:4*gi];
    end
  endgenerate
  assign lzb_ok = (idx_next == 2'd0) | hi_nz[idx_next];
`else
  assign lzb_ok = 1'b1;
`endif

  always_comb begin
    cnt_next = cnt_reg;
    idx_next = idx_reg;
    if (!run_reg) begin
      cnt_next = '0;
      idx_next = 2'd0;
    end else if (cnt_reg == LAST) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end

    frm_next = (cnt_next == '0) && (idx_next == 2'd0);
    sh_next  = frm_next ? val : sh_reg;
    bcd_next = nib[idx_next];

    lit      = ~blank[idx_next] & guard_ok & lzb_ok;
    en_next  = lit;
    an_next  = lit ? ~(4'b0001 << idx_next) : 4'b1111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg <= 1'b0;
      cnt_reg <= '0;
      idx_reg <= 2'd0;
      sh_reg  <= 16'h0000;
      bcd_reg <= 4'h0;
      en_reg  <= 1'b0;
      an_reg  <= 4'b1111;
      frm_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      sh_reg  <= sh_next;
      bcd_reg <= bcd_next;
      en_reg  <= en_next;
      an_reg  <= an_next;
      frm_reg <= frm_next;
    end
  end

  assign bcd = bcd_reg;
  assign en  = en_reg;
  assign an  = an_reg;
  assign frm = frm_reg;

endmodule
